// File: rtl/return_stack.sv
// Circular return-address stack for JMS/BBL subroutine linkage.
// A push while full overwrites the oldest entry; overflow and underflow are sticky error flags.
module return_stack #(
  parameter int PC_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     err_clr,
  output logic [PC_W-1:0]          top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_WRAP,
    OP_POP,
    OP_REPLACE,
    OP_UNDER
  } op_e;

  logic [PC_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  op_e              op;

  // DEPTH is a power of two, so pointer arithmetic wraps modulo DEPTH for free.
  assign rp    = wp - PTR_W'(1);
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign top   = empty ? '0 : mem[rp];

  // NOTE: every path assigns op after the default, so no latch is inferred.
  always_comb begin
    op = OP_HOLD;
    if (push && pop && !empty) op = OP_REPLACE;
    else if (push)             op = full ? OP_WRAP : OP_PUSH;
    else if (pop)              op = empty ? OP_UNDER : OP_POP;
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; the memory array is reset too, keeping top X-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (op)
        OP_PUSH: begin
          mem[wp] <= pc_in;
          wp      <= wp + PTR_W'(1);
          count   <= count + CNT_W'(1);
        end
        OP_WRAP: begin
          mem[wp] <= pc_in;
          wp      <= wp + PTR_W'(1);
        end
        OP_POP: begin
          wp    <= rp;
          count <= count - CNT_W'(1);
        end
        OP_REPLACE: mem[rp] <= pc_in;
        default: ;
      endcase
    end
  end

  // Setting events take priority over err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (op == OP_WRAP)  | (overflow  & ~err_clr);
      underflow <= (op == OP_UNDER) | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios plus random traffic
// compared against a queue-based stack model.
module tb_return_stack;

  localparam int PC_W  = 8;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            push, pop, err_clr;
  logic [PC_W-1:0] pc_in;
  logic [PC_W-1:0] top;
  logic [2:0]      count;
  logic            empty, full, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PC_W-1:0] mq [$];
  logic            m_ovf, m_unf;

  return_stack #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .pc_in(pc_in),
    .err_clr(err_clr), .top(top), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] m_top();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Stack semantics: push+pop on a non-empty stack replaces the top; a push
  // beyond capacity drops the oldest entry; a pop from empty only flags.
  task automatic model_step(input logic p, input logic o, input logic [PC_W-1:0] d, input logic c);
    logic set_o, set_u;
    set_o = 1'b0;
    set_u = 1'b0;
    if (p && o && mq.size() > 0) begin
      mq[mq.size()-1] = d;
    end else if (p) begin
      mq.push_back(d);
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        set_o = 1'b1;
      end
    end else if (o) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else set_u = 1'b1;
    end
    m_ovf = set_o | (m_ovf & ~c);
    m_unf = set_u | (m_unf & ~c);
  endtask

  task automatic check_all(input string tag);
    check({tag, "/top"},       32'(top),       32'(m_top()));
    check({tag, "/count"},     32'(count),     32'(mq.size()));
    check({tag, "/empty"},     32'(empty),     32'(mq.size() == 0));
    check({tag, "/full"},      32'(full),      32'(mq.size() == DEPTH));
    check({tag, "/overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, "/underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic cycle(input string tag, input logic p, input logic o,
                       input logic [PC_W-1:0] d, input logic c);
    push    = p;
    pop     = o;
    pc_in   = d;
    err_clr = c;
    @(posedge clk);
    #1;
    model_step(p, o, d, c);
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; pc_in = '0;
    model_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1'b1;

    // Basic push/pop
    cycle("p10", 1, 0, 8'h10, 0);
    cycle("p20", 1, 0, 8'h20, 0);
    cycle("p30", 1, 0, 8'h30, 0);
    check("basic_top3", 32'(top), 32'h30);
    cycle("pop1", 0, 1, 8'h00, 0);
    check("basic_top2", 32'(top), 32'h20);
    cycle("pop2", 0, 1, 8'h00, 0);
    cycle("pop3", 0, 1, 8'h00, 0);
    check("basic_empty", 32'(empty), 32'd1);

    // Overflow wrap
    for (int i = 1; i <= 4; i++) cycle("fill", 1, 0, 8'(i), 0);
    check("wrap_full", 32'(full), 32'd1);
    cycle("p05", 1, 0, 8'h05, 0);
    check("wrap_ovf", 32'(overflow), 32'd1);
    check("wrap_top", 32'(top), 32'h05);
    for (int i = 0; i < 4; i++) begin
      check("wrap_pop_val", 32'(top), 32'(5 - i));
      cycle("drain", 0, 1, 8'h00, 0);
    end
    cycle("ovf_clr", 0, 0, 8'h00, 1);

    // Underflow and clear; clear coinciding with a new underflow keeps it set
    cycle("under", 0, 1, 8'h00, 0);
    check("under_flag", 32'(underflow), 32'd1);
    cycle("under_clr", 0, 0, 8'h00, 1);
    check("under_cleared", 32'(underflow), 32'd0);
    cycle("under_setwins", 0, 1, 8'h00, 1);

    // Replace top, and push+pop while empty
    cycle("p40", 1, 0, 8'h40, 0);
    cycle("repl41", 1, 1, 8'h41, 0);
    check("repl_top", 32'(top), 32'h41);
    cycle("pop41", 0, 1, 8'h00, 0);
    cycle("pp_empty", 1, 1, 8'h50, 0);
    check("pp_empty_top", 32'(top), 32'h50);
    check("pp_empty_unf", 32'(underflow), 32'd1);
    cycle("clr_all", 0, 1, 8'h00, 1);

    // JMS pushes return address, BBL later pops it
    cycle("jms", 1, 0, 8'h21, 0);
    cycle("idle", 0, 0, 8'hFF, 0);
    cycle("idle", 0, 0, 8'hFF, 0);
    check("bbl_top", 32'(top), 32'h21);
    cycle("bbl", 0, 1, 8'h00, 0);

    // Asynchronous reset between edges, held while push is asserted
    cycle("pAA", 1, 0, 8'hAA, 0);
    cycle("pBB", 1, 0, 8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    push = 1'b1; pc_in = 8'hCC;
    @(posedge clk); #1;
    check_all("rst_hold");
    push = 1'b0;
    #3 rst_n = 1'b1;
    cycle("post_rst", 1, 0, 8'h77, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic p, o, c;
      r = $urandom_range(0, 99);
      p = (r < 45) || (r >= 85 && r < 95);
      o = (r >= 45 && r < 85) || (r >= 85 && r < 95);
      c = ($urandom_range(0, 15) == 0);
      cycle("rand", p, o, 8'($urandom), c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
